// File: rtl/fx_sub_rr_sched.sv
// Round-robin front end that shares one registered fixed-point subtractor among
// N_REQ requesters, tagging each issued op so its result returns to the issuer.
module fx_sub_rr_sched #(
  parameter int DATA_WIDTH  = 32,
  parameter int N_REQ       = 4,
  parameter int SUB_LATENCY = 1,
  parameter int ID_W        = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_flush,
  input  logic [N_REQ-1:0]            i_req_valid,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data_0,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data_1,
  output logic [DATA_WIDTH-1:0]       o_sub_data_0,
  output logic [DATA_WIDTH-1:0]       o_sub_data_1,
  input  logic [DATA_WIDTH-1:0]       i_sub_result,
  output logic [N_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]       o_rsp_data,
  output logic                        o_busy
);

  localparam int NSTG = SUB_LATENCY + 1;
  localparam int CW   = ID_W + 1;

  logic [ID_W-1:0]       r_rr_ptr;
  logic [NSTG-1:0]       r_tag_vld;
  logic [ID_W-1:0]       r_tag_id [NSTG];
  logic [DATA_WIDTH-1:0] r_sub_data_0;
  logic [DATA_WIDTH-1:0] r_sub_data_1;
  logic [N_REQ-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  logic [N_REQ-1:0]      w_grant;
  logic [ID_W-1:0]       w_win_id;
  logic                  w_found;
  logic                  w_xfer;
  logic [ID_W-1:0]       w_next_ptr;

  // Scan from r_rr_ptr upward with wrap; the first requester found wins.
  always_comb begin
    logic [CW-1:0] cand;
    w_grant  = '0;
    w_win_id = '0;
    w_found  = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = CW'(r_rr_ptr) + CW'(i);
      if (cand >= CW'(N_REQ)) begin
        cand = cand - CW'(N_REQ);
      end
      if (!w_found && i_req_valid[cand]) begin
        w_found  = 1'b1;
        w_win_id = cand[ID_W-1:0];
      end
    end
    if (w_found && !i_flush) begin
      w_grant[w_win_id] = 1'b1;
    end
  end

  assign w_xfer      = w_found & ~i_flush;
  assign w_next_ptr  = (w_win_id == ID_W'(N_REQ - 1)) ? '0 : w_win_id + 1'b1;
  assign o_req_ready = w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_sub_data_0 <= '0;
      r_sub_data_1 <= '0;
    end else if (w_xfer) begin
      r_rr_ptr     <= w_next_ptr;
      r_sub_data_0 <= i_req_data_0[w_win_id*DATA_WIDTH +: DATA_WIDTH];
      r_sub_data_1 <= i_req_data_1[w_win_id*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Tag stage 0 is written alongside the operands; later stages shift unconditionally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld[0] <= 1'b0;
      r_tag_id[0]  <= '0;
    end else begin
      r_tag_vld[0] <= w_xfer;
      r_tag_id[0]  <= w_win_id;
    end
  end

  generate
    for (genvar gi = 1; gi < NSTG; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag_vld[gi] <= 1'b0;
          r_tag_id[gi]  <= '0;
        end else begin
          r_tag_vld[gi] <= r_tag_vld[gi-1] & ~i_flush;
          r_tag_id[gi]  <= r_tag_id[gi-1];
        end
      end
    end
  endgenerate

  // A flush also suppresses the op whose result is arriving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (r_tag_vld[NSTG-1] && !i_flush) begin
        r_rsp_valid[r_tag_id[NSTG-1]] <= 1'b1;
        r_rsp_data                    <= i_sub_result;
      end
    end
  end

  assign o_sub_data_0 = r_sub_data_0;
  assign o_sub_data_1 = r_sub_data_1;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_data   = r_rsp_data;
  assign o_busy       = |r_tag_vld;

endmodule

// File: tb/tb_fx_sub_rr_sched.sv
// Directed table-driven bench for fx_sub_rr_sched with a behavioural FX_Sub model.
module tb_fx_sub_rr_sched;

  logic         clk;
  logic         rst_n;
  logic         i_flush;
  logic [3:0]   i_req_valid;
  logic [3:0]   o_req_ready;
  logic [127:0] i_req_data_0;
  logic [127:0] i_req_data_1;
  logic [31:0]  o_sub_data_0;
  logic [31:0]  o_sub_data_1;
  logic [31:0]  i_sub_result;
  logic [3:0]   o_rsp_valid;
  logic [31:0]  o_rsp_data;
  logic         o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  fx_sub_rr_sched #(
    .DATA_WIDTH(32), .N_REQ(4), .SUB_LATENCY(1), .ID_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_data_0(i_req_data_0), .i_req_data_1(i_req_data_1),
    .o_sub_data_0(o_sub_data_0), .o_sub_data_1(o_sub_data_1),
    .i_sub_result(i_sub_result),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle registered subtractor, as FX_Sub behaves.
  initial i_sub_result = '0;
  always @(posedge clk) i_sub_result <= o_sub_data_0 - o_sub_data_1;

  typedef struct {
    logic [3:0]  valid;
    logic        flush;
    int          dsel;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_rv;
    logic [31:0] exp_rd;
    logic        exp_busy;
  } row_t;

  row_t         rows [$];
  logic [127:0] s_d0 [5];
  logic [127:0] s_d1 [5];

  task automatic add(input logic [3:0] v, input logic f, input int ds, input logic [3:0] rdy,
                     input logic [3:0] rv, input logic [31:0] rd, input logic b);
    row_t r;
    r.valid = v; r.flush = f; r.dsel = ds; r.exp_ready = rdy;
    r.exp_rv = rv; r.exp_rd = rd; r.exp_busy = b;
    rows.push_back(r);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input int ds, input logic [3:0] v, input logic f);
    i_req_valid  = v;
    i_flush      = f;
    i_req_data_0 = s_d0[ds];
    i_req_data_1 = s_d1[ds];
  endtask

  initial begin
    s_d0[0] = '0;                                  s_d1[0] = '0;
    s_d0[1] = {96'd0, 32'd10};                     s_d1[1] = {96'd0, 32'd3};
    s_d0[2] = '0;                                  s_d1[2] = {32'd0, 32'd1, 64'd0};
    s_d0[3] = {32'd5, 32'd0, 32'd100, 32'd0};      s_d1[3] = {32'd20, 32'd0, 32'd1, 32'd0};
    s_d0[4] = {32'd400, 32'd300, 32'd200, 32'd100}; s_d1[4] = {32'd4, 32'd3, 32'd2, 32'd1};

    // Single op on req0: 10-3=7, response 3 cycles after accept.
    add(4'b0001, 0, 1, 4'b0001, 4'b0000, 32'd0, 0);
    add(4'b0000, 0, 0, 4'b0000, 4'b0000, 32'd0, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b0000, 32'd0, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b0001, 32'd7, 0);
    // Req2: 0-1 wraps to all ones.
    add(4'b0100, 0, 2, 4'b0100, 4'b0000, 32'd7, 0);
    add(4'b0000, 0, 0, 4'b0000, 4'b0000, 32'd7, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b0000, 32'd7, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b0100, 32'hFFFF_FFFF, 0);
    // Req1 moves pointer to 2, then req1+req3 -> req3 first, then req1.
    add(4'b0010, 0, 3, 4'b0010, 4'b0000, 32'hFFFF_FFFF, 0);
    add(4'b1010, 0, 3, 4'b1000, 4'b0000, 32'hFFFF_FFFF, 1);
    add(4'b0010, 0, 3, 4'b0010, 4'b0000, 32'hFFFF_FFFF, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b0010, 32'd99, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b1000, 32'hFFFF_FFF1, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b0010, 32'd99, 0);
    // Req3 returns pointer to 0, then all four continuously.
    add(4'b1000, 0, 4, 4'b1000, 4'b0000, 32'd99, 0);
    add(4'b1111, 0, 4, 4'b0001, 4'b0000, 32'd99, 1);
    add(4'b1111, 0, 4, 4'b0010, 4'b0000, 32'd99, 1);
    add(4'b1111, 0, 4, 4'b0100, 4'b1000, 32'd396, 1);
    add(4'b1111, 0, 4, 4'b1000, 4'b0001, 32'd99, 1);
    add(4'b1111, 0, 4, 4'b0001, 4'b0010, 32'd198, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b0100, 32'd297, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b1000, 32'd396, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b0001, 32'd99, 0);
    // Two accepts then flush: no responses, no grant, pointer kept.
    add(4'b0100, 0, 4, 4'b0100, 4'b0000, 32'd99, 0);
    add(4'b1000, 0, 4, 4'b1000, 4'b0000, 32'd99, 1);
    add(4'b1111, 1, 4, 4'b0000, 4'b0000, 32'd99, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b0000, 32'd99, 0);
    add(4'b0000, 0, 0, 4'b0000, 4'b0000, 32'd99, 0);
    add(4'b0000, 0, 0, 4'b0000, 4'b0000, 32'd99, 0);
    add(4'b1111, 0, 4, 4'b0001, 4'b0000, 32'd99, 0);
    add(4'b0000, 0, 0, 4'b0000, 4'b0000, 32'd99, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b0000, 32'd99, 1);
    add(4'b0000, 0, 0, 4'b0000, 4'b0001, 32'd99, 0);

    rst_n = 1'b0;
    apply(0, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", -1, 32'(o_rsp_valid), 32'd0);
    chk("reset_rsp_data", -1, o_rsp_data, 32'd0);
    chk("reset_busy", -1, 32'(o_busy), 32'd0);
    chk("reset_sub_data_0", -1, o_sub_data_0, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i].dsel, rows[i].valid, rows[i].flush);
      @(negedge clk);
      chk("ready", i, 32'(o_req_ready), 32'(rows[i].exp_ready));
      chk("rsp_valid", i, 32'(o_rsp_valid), 32'(rows[i].exp_rv));
      chk("rsp_data", i, o_rsp_data, rows[i].exp_rd);
      chk("busy", i, 32'(o_busy), 32'(rows[i].exp_busy));
      $display("[TB] step %0d valid=%b flush=%b ready=%b rsp=%b data=%h busy=%b",
               i, rows[i].valid, rows[i].flush, o_req_ready, o_rsp_valid, o_rsp_data, o_busy);
      @(posedge clk); #1;
    end

    // Async reset with three ops in flight (pointer is 1: grants 1,2,3).
    for (int i = 0; i < 3; i++) begin
      apply(4, 4'b1111, 1'b0);
      @(negedge clk);
      chk("rst_seq_grant", i, 32'(o_req_ready), 32'(4'b0010 << i));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rst_seq_rsp_before", 0, 32'(o_rsp_valid), 32'(4'b0010));
    chk("rst_seq_data_before", 0, o_rsp_data, 32'd198);
    #2;
    apply(0, 4'b0000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 0, 32'(o_rsp_valid), 32'd0);
    chk("async_rsp_data", 0, o_rsp_data, 32'd0);
    chk("async_busy", 0, 32'(o_busy), 32'd0);
    chk("async_ready", 0, 32'(o_req_ready), 32'd0);
    chk("async_sub_data_0", 0, o_sub_data_0, 32'd0);
    chk("async_sub_data_1", 0, o_sub_data_1, 32'd0);
    $display("[TB] async reset: rsp=%b data=%h busy=%b", o_rsp_valid, o_rsp_data, o_busy);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4, 4'b1111, 1'b0);
    #1;
    chk("post_reset_grant", 0, 32'(o_req_ready), 32'(4'b0001));
    @(posedge clk); #1;
    apply(0, 4'b0000, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("post_reset_rsp", i, 32'(o_rsp_valid), (i == 3) ? 32'(4'b0001) : 32'd0);
      if (i == 3) chk("post_reset_data", i, o_rsp_data, 32'd99);
      @(posedge clk); #1;
    end
    $display("[TB] post-reset op: rsp=%b data=%h", o_rsp_valid, o_rsp_data);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
